// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the load/store access unit.
// No logic; wiring only.
// slave = access unit side, master = datapath/memory environment side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
) ();
  // datapath request/response
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_address;
  logic [31:0]       req_writedata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_error;
  // word-aligned data memory port
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_waitrequest;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_address, req_writedata,
    input  mem_readdata, mem_waitrequest,
    output req_ready, resp_valid, resp_data, resp_error,
    output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_address, req_writedata,
    output mem_readdata, mem_waitrequest,
    input  req_ready, resp_valid, resp_data, resp_error,
    input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit: one or two word-aligned memory accesses per request.
// Latency: aligned 2 cycles, straddling 3, misaligned error 1; +1 per waitrequest cycle.
// Backpressure: req_ready only in IDLE; mem_waitrequest holds all memory outputs stable.
module mem_access_unit #(
  parameter int ADDR_W          = 32,
  parameter bit ALLOW_UNALIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_write;
  logic              r_signed;
  logic              r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rd0;
  logic [31:0]       r_rd1;

  logic              w_accept;
  logic [1:0]        w_req_size;
  logic              w_req_mis;
  logic [1:0]        w_off;
  logic [3:0]        w_nmask;
  logic [7:0]        w_be8;
  logic              w_straddle;
  logic [63:0]       w_wd64;
  logic [ADDR_W-1:0] w_addr1;
  logic [ADDR_W-1:0] w_addr2;
  logic              w_in_acc;
  logic [31:0]       w_raw;
  logic [31:0]       w_ext;

  // Size code 3 behaves as a word everywhere, so normalise it once at acceptance.
  assign w_accept   = (r_state == S_IDLE) && bus.req_valid;
  assign w_req_size = (bus.req_size == 2'd3) ? 2'd2 : bus.req_size;
  assign w_req_mis  = ((w_req_size == 2'd1) && bus.req_address[0]) ||
                      ((w_req_size == 2'd2) && (bus.req_address[1:0] != 2'b00));

  // Lane mask shifted across an 8-lane window: low half is the first word, high half the second.
  assign w_off      = r_addr[1:0];
  assign w_nmask    = (r_size == 2'd0) ? 4'b0001 : (r_size == 2'd1) ? 4'b0011 : 4'b1111;
  assign w_be8      = {4'b0000, w_nmask} << w_off;
  assign w_straddle = |w_be8[7:4];
  assign w_wd64     = {32'd0, r_wdata} << {w_off, 3'b000};
  assign w_addr1    = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_addr2    = w_addr1 + ADDR_W'(4);
  assign w_in_acc   = (r_state == S_ACC1) || (r_state == S_ACC2);

  // Both captured words viewed as one little-endian 8-byte window, realigned to the request offset.
  assign w_raw = 32'({r_rd1, r_rd0} >> {w_off, 3'b000});

  // Sign/zero extension of the assembled load bytes.
  always_comb begin
    w_ext = w_raw;
    case (r_size)
      2'd0:    w_ext = {{24{r_signed & w_raw[7]}}, w_raw[7:0]};
      2'd1:    w_ext = {{16{r_signed & w_raw[15]}}, w_raw[15:0]};
      default: ;
    endcase
  end

  // Next-state logic; memory accesses advance only when waitrequest is low.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (!ALLOW_UNALIGNED && w_req_mis) ? S_RESP : S_ACC1;
      S_ACC1: if (!bus.mem_waitrequest) w_state_nxt = w_straddle ? S_ACC2 : S_RESP;
      S_ACC2: if (!bus.mem_waitrequest) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset wins over clk_enable.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else if (clk_enable) r_state <= w_state_nxt;
  end

  // Request fields latched at acceptance; read words captured when each access completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rd0    <= 32'd0;
      r_rd1    <= 32'd0;
    end else if (clk_enable) begin
      if (w_accept) begin
        r_write  <= bus.req_write;
        r_signed <= bus.req_signed;
        r_err    <= !ALLOW_UNALIGNED && w_req_mis;
        r_size   <= w_req_size;
        r_addr   <= bus.req_address;
        r_wdata  <= bus.req_writedata;
        r_rd0    <= 32'd0;
        r_rd1    <= 32'd0;
      end
      if ((r_state == S_ACC1) && !bus.mem_waitrequest && !r_write) r_rd0 <= bus.mem_readdata;
      if ((r_state == S_ACC2) && !bus.mem_waitrequest && !r_write) r_rd1 <= bus.mem_readdata;
    end
  end

  // Outputs decoded purely from registers, so they hold under waitrequest and clk_enable=0.
  always_comb begin
    bus.req_ready      = (r_state == S_IDLE);
    bus.resp_valid     = (r_state == S_RESP);
    bus.resp_error     = (r_state == S_RESP) && r_err;
    bus.resp_data      = 32'd0;
    bus.mem_read       = w_in_acc && !r_write;
    bus.mem_write      = w_in_acc && r_write;
    bus.mem_address    = '0;
    bus.mem_byteenable = 4'b0000;
    bus.mem_writedata  = 32'd0;
    if ((r_state == S_RESP) && !r_write && !r_err) bus.resp_data = w_ext;
    if (r_state == S_ACC1) begin
      bus.mem_address    = w_addr1;
      bus.mem_byteenable = w_be8[3:0];
      if (r_write) bus.mem_writedata = w_wd64[31:0];
    end else if (r_state == S_ACC2) begin
      bus.mem_address    = w_addr2;
      bus.mem_byteenable = w_be8[7:4];
      if (r_write) bus.mem_writedata = w_wd64[63:32];
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset, clk_enable, sel;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_address, req_writedata;
  logic        mem_wait;
  logic [31:0] mem [0:15];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32)) bus_a ();
  mem_access_unit_if #(.ADDR_W(32)) bus_b ();

  mem_access_unit #(.ADDR_W(32), .ALLOW_UNALIGNED(1'b1)) dut_a (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus_a));
  mem_access_unit #(.ADDR_W(32), .ALLOW_UNALIGNED(1'b0)) dut_b (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus_b));

  assign bus_a.req_valid       = req_valid & ~sel;
  assign bus_b.req_valid       = req_valid & sel;
  assign bus_a.req_write       = req_write;
  assign bus_b.req_write       = req_write;
  assign bus_a.req_size        = req_size;
  assign bus_b.req_size        = req_size;
  assign bus_a.req_signed      = req_signed;
  assign bus_b.req_signed      = req_signed;
  assign bus_a.req_address     = req_address;
  assign bus_b.req_address     = req_address;
  assign bus_a.req_writedata   = req_writedata;
  assign bus_b.req_writedata   = req_writedata;
  assign bus_a.mem_readdata    = mem[bus_a.mem_address[5:2]];
  assign bus_b.mem_readdata    = mem[bus_b.mem_address[5:2]];
  assign bus_a.mem_waitrequest = mem_wait;
  assign bus_b.mem_waitrequest = mem_wait;

  // observed outputs of the selected DUT
  logic        o_ready, o_rv, o_rerr, o_rd, o_wr;
  logic [31:0] o_rdata, o_addr, o_wd;
  logic [3:0]  o_be;
  assign o_ready = sel ? bus_b.req_ready      : bus_a.req_ready;
  assign o_rv    = sel ? bus_b.resp_valid     : bus_a.resp_valid;
  assign o_rerr  = sel ? bus_b.resp_error     : bus_a.resp_error;
  assign o_rdata = sel ? bus_b.resp_data      : bus_a.resp_data;
  assign o_rd    = sel ? bus_b.mem_read       : bus_a.mem_read;
  assign o_wr    = sel ? bus_b.mem_write      : bus_a.mem_write;
  assign o_addr  = sel ? bus_b.mem_address    : bus_a.mem_address;
  assign o_be    = sel ? bus_b.mem_byteenable : bus_a.mem_byteenable;
  assign o_wd    = sel ? bus_b.mem_writedata  : bus_a.mem_writedata;

  typedef struct {
    logic        sel;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    int          waits;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_nacc;
    logic [3:0]  exp_be1;
    logic [3:0]  exp_be2;
    logic [31:0] exp_a1;
    logic [31:0] exp_a2;
    logic [31:0] exp_wd1;
    logic [31:0] exp_wd2;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  // results of the last run_req
  int          got_lat, got_nacc;
  logic [31:0] got_data;
  logic        got_err, got_bad;
  logic [3:0]  got_be [2];
  logic [31:0] got_a [2];
  logic [31:0] got_wd [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v);
    int          wcnt;
    logic        prev_wait;
    logic [31:0] pa, pw;
    logic [3:0]  pb;
    @(negedge clk);
    sel = v.sel; req_write = v.wr; req_size = v.sz; req_signed = v.sg;
    req_address = v.addr; req_writedata = v.wd; req_valid = 1'b1; mem_wait = 1'b0;
    #1;
    chk("ready_before_req", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    got_lat = -1; got_nacc = 0; got_data = 32'hDEADDEAD; got_err = 1'bx; got_bad = 1'b0;
    got_be[0] = 4'h0; got_be[1] = 4'h0; got_a[0] = 32'h0; got_a[1] = 32'h0;
    got_wd[0] = 32'h0; got_wd[1] = 32'h0;
    wcnt = 0; prev_wait = 1'b0; pa = 32'h0; pw = 32'h0; pb = 4'h0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (o_rd && o_wr) got_bad = 1'b1;
      if (prev_wait && (o_addr !== pa || o_be !== pb || o_wd !== pw || !(o_rd || o_wr)))
        got_bad = 1'b1;
      if (o_rv) begin
        got_lat = c; got_data = o_rdata; got_err = o_rerr;
        break;
      end
      if (o_rd || o_wr) begin
        if (wcnt < v.waits) begin
          mem_wait = 1'b1;
          wcnt++;
        end else begin
          mem_wait = 1'b0;
          if (got_nacc < 2) begin
            got_be[got_nacc] = o_be; got_a[got_nacc] = o_addr; got_wd[got_nacc] = o_wd;
          end
          if (o_wr)
            for (int k = 0; k < 4; k++)
              if (o_be[k]) mem[o_addr[5:2]][8*k +: 8] = o_wd[8*k +: 8];
          got_nacc++;
        end
        pa = o_addr; pb = o_be; pw = o_wd;
      end else begin
        mem_wait = 1'b0;
      end
      prev_wait = mem_wait;
    end
    mem_wait = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   lat;

    //        sel wr sz sg addr          wd           w  data          e lat n be1   be2   a1            a2            wd1           wd2
    vecs[0]  = '{0, 0, 1, 1, 32'h7,        32'h0,       0, 32'h00005501, 0, 3, 2, 4'h8, 4'h1, 32'h4,        32'h8,        32'h0,        32'h0};
    vecs[1]  = '{0, 0, 0, 1, 32'hB,        32'h0,       0, 32'hFFFFFFAA, 0, 2, 1, 4'h8, 4'h0, 32'h8,        32'h0,        32'h0,        32'h0};
    vecs[2]  = '{0, 0, 0, 0, 32'hB,        32'h0,       0, 32'h000000AA, 0, 2, 1, 4'h8, 4'h0, 32'h8,        32'h0,        32'h0,        32'h0};
    vecs[3]  = '{0, 0, 2, 0, 32'h6,        32'h0,       0, 32'hCC550122, 0, 3, 2, 4'hC, 4'h3, 32'h4,        32'h8,        32'h0,        32'h0};
    vecs[4]  = '{0, 0, 2, 0, 32'h4,        32'h0,       3, 32'h01223344, 0, 5, 1, 4'hF, 4'h0, 32'h4,        32'h0,        32'h0,        32'h0};
    vecs[5]  = '{0, 0, 1, 1, 32'h9,        32'h0,       0, 32'hFFFFBBCC, 0, 2, 1, 4'h6, 4'h0, 32'h8,        32'h0,        32'h0,        32'h0};
    vecs[6]  = '{0, 0, 1, 0, 32'h9,        32'h0,       0, 32'h0000BBCC, 0, 2, 1, 4'h6, 4'h0, 32'h8,        32'h0,        32'h0,        32'h0};
    vecs[7]  = '{1, 0, 1, 1, 32'h7,        32'h0,       0, 32'h00000000, 1, 1, 0, 4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[8]  = '{1, 0, 1, 0, 32'h6,        32'h0,       0, 32'h00000122, 0, 2, 1, 4'hC, 4'h0, 32'h4,        32'h0,        32'h0,        32'h0};
    vecs[9]  = '{1, 0, 2, 0, 32'h5,        32'h0,       0, 32'h00000000, 1, 1, 0, 4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[10] = '{0, 0, 2, 0, 32'hFFFFFFFE, 32'h0,       0, 32'h77881122, 0, 3, 2, 4'hC, 4'h3, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0};
    vecs[11] = '{0, 1, 1, 0, 32'h7,        32'h0000BEEF,0, 32'h00000000, 0, 3, 2, 4'h8, 4'h1, 32'h4,        32'h8,        32'hEF000000, 32'h000000BE};
    vecs[12] = '{0, 0, 3, 0, 32'h4,        32'h0,       0, 32'hEF223344, 0, 2, 1, 4'hF, 4'h0, 32'h4,        32'h0,        32'h0,        32'h0};
    vecs[13] = '{1, 0, 0, 1, 32'hA,        32'h0,       0, 32'hFFFFFFBB, 0, 2, 1, 4'h4, 4'h0, 32'h8,        32'h0,        32'h0,        32'h0};
    vecs[14] = '{0, 1, 0, 0, 32'h3,        32'h000000A5,0, 32'h00000000, 0, 2, 1, 4'h8, 4'h0, 32'h0,        32'h0,        32'hA5000000, 32'h0};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0]  = 32'h55667788;
    mem[1]  = 32'h01223344;
    mem[2]  = 32'hAABBCC55;
    mem[15] = 32'h11223344;

    reset = 1'b0; clk_enable = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_address = 32'h0; req_writedata = 32'h0; mem_wait = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready",      32'(o_ready), 32'd1);
    chk("rst_resp_valid", 32'(o_rv),    32'd0);
    chk("rst_resp_error", 32'(o_rerr),  32'd0);
    chk("rst_resp_data",  o_rdata,      32'd0);
    chk("rst_mem_read",   32'(o_rd),    32'd0);
    chk("rst_mem_write",  32'(o_wr),    32'd0);
    chk("rst_byteenable", 32'(o_be),    32'd0);
    chk("rst_address",    o_addr,       32'd0);
    chk("rst_writedata",  o_wd,         32'd0);
    chk("rst_b_ready",    32'(bus_b.req_ready), 32'd1);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_req(vecs[i]);
      chk($sformatf("v%0d_data", i),    got_data,        vecs[i].exp_data);
      chk($sformatf("v%0d_error", i),   32'(got_err),    32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(got_lat),    32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_naccess", i), 32'(got_nacc),   32'(vecs[i].exp_nacc));
      chk($sformatf("v%0d_protocol", i), 32'(got_bad),   32'd0);
      if (vecs[i].exp_nacc >= 1) begin
        chk($sformatf("v%0d_be1", i),   32'(got_be[0]),  32'(vecs[i].exp_be1));
        chk($sformatf("v%0d_addr1", i), got_a[0],        vecs[i].exp_a1);
        if (vecs[i].wr) chk($sformatf("v%0d_wd1", i), got_wd[0], vecs[i].exp_wd1);
      end
      if (vecs[i].exp_nacc == 2) begin
        chk($sformatf("v%0d_be2", i),   32'(got_be[1]),  32'(vecs[i].exp_be2));
        chk($sformatf("v%0d_addr2", i), got_a[1],        vecs[i].exp_a2);
        if (vecs[i].wr) chk($sformatf("v%0d_wd2", i), got_wd[1], vecs[i].exp_wd2);
      end
      @(negedge clk);
      chk($sformatf("v%0d_resp_pulse", i), 32'(o_rv),    32'd0);
      chk($sformatf("v%0d_ready_after", i), 32'(o_ready), 32'd1);
    end

    chk("mem_word0", mem[0], 32'hA5667788);
    chk("mem_word4", mem[1], 32'hEF223344);
    chk("mem_word8", mem[2], 32'hAABBCCBE);

    // reset during the second access of a straddling store
    @(negedge clk);
    sel = 1'b0; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_address = 32'h7; req_writedata = 32'h0000BEEF; req_valid = 1'b1; mem_wait = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_acc1_write", 32'(o_wr), 32'd1);
    @(negedge clk);
    chk("rst_mid_acc2_be", 32'(o_be), 32'h1);
    chk("rst_mid_acc2_addr", o_addr, 32'h8);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_write_dropped", 32'(o_wr), 32'd0);
    chk("rst_mid_be_dropped",    32'(o_be), 32'd0);
    chk("rst_mid_ready",         32'(o_ready), 32'd1);
    seen = o_rv;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (o_rv) seen = 1'b1;
    end
    chk("rst_mid_no_resp", 32'(seen), 32'd0);

    // clk_enable low for two cycles while the first access is on the bus
    @(negedge clk);
    sel = 1'b0; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_address = 32'h4; req_writedata = 32'h0; req_valid = 1'b1; mem_wait = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    clk_enable = 1'b0;
    lat = -1;
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (c == 2) chk("cke_frozen_read", 32'(o_rd), 32'd1);
      if (c == 3) clk_enable = 1'b1;
      if (o_rv) begin
        lat = c;
        chk("cke_data", o_rdata, 32'hEF223344);
        break;
      end
    end
    chk("cke_latency", 32'(lat), 32'd4);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
